doodle_vmotion: RTL

Parametrised vertical-motion engine for the doodle sprite: signed velocity, gravity, jump impulse, and landing detection against `NUM_PLAT` platforms, all on a one-cycle-per-frame update. It sits between the platform generator (platform positions) and the VGA sprite renderer (`d_y`), alongside the horizontal doodle control (`d_x`). It supersedes the fixed-position vertical block with a full physics state machine, plus game-over and optional screen-scroll outputs.

---
 rtl/doodle_pkg.sv | 20 ++
 rtl/plat_hit_detect.sv | 22 ++
 rtl/doodle_vmotion.sv | 135 +++++++++++++
 3 files changed

// File: rtl/doodle_pkg.sv
// doodle_pkg: vertical-motion state enum, default geometry/physics constants
// and the bit-offset helper for packed platform vectors.
package doodle_pkg;
    typedef enum logic [1:0] {IDLE, RISE, FALL, DEAD} state_e;
    localparam int DEF_Y_W         = 10;
    localparam int DEF_V_W         = 8;
    localparam int DEF_NUM_PLAT    = 3;
    localparam int DEF_SIZE        = 50;
    localparam int DEF_PLAT_W      = 75;
    localparam int DEF_GRAVITY     = 2;
    localparam int DEF_JUMP_V      = 20;
    localparam int DEF_V_MAX       = 16;
    localparam int DEF_Y_START     = 510;
    localparam int DEF_Y_TOP       = 35;
    localparam int DEF_Y_FLOOR     = 515;
    localparam int DEF_SCROLL_LINE = 200;
    function automatic int plat_lsb(input int i, input int w);
        return i * w;
    endfunction
endpackage

// File: rtl/plat_hit_detect.sv
// plat_hit_detect: landing test of the doodle against one platform for the
// current frame; operands are Y_W+2 signed so the sums cannot wrap.
module plat_hit_detect #(
    parameter int Y_W    = 10,
    parameter int SIZE   = 50,
    parameter int PLAT_W = 75
) (
    input  logic signed [Y_W+1:0] d_y,
    input  logic signed [Y_W+1:0] y_nxt,
    input  logic        [Y_W-1:0] d_x,
    input  logic        [Y_W-1:0] vpos,
    input  logic        [Y_W-1:0] hpos,
    output logic                  hit
);
    localparam int S = Y_W + 2;
    logic signed [S-1:0] v, h, x;
    assign v = $signed({2'b00, vpos});
    assign h = $signed({2'b00, hpos});
    assign x = $signed({2'b00, d_x});
    assign hit = (d_y + S'(SIZE) <= v) && (y_nxt + S'(SIZE) >= v) &&
                 (x + S'(SIZE) > h) && (x < h + S'(PLAT_W));
endmodule

// File: rtl/doodle_vmotion.sv
// doodle_vmotion: per-frame vertical physics (IDLE/RISE/FALL/DEAD) with platform landing.
// Define DOODLE_SCROLL_EN to pin the rise at SCROLL_LINE and report the world shift.
module doodle_vmotion import doodle_pkg::*; #(
    parameter int Y_W         = DEF_Y_W,
    parameter int V_W         = DEF_V_W,
    parameter int NUM_PLAT    = DEF_NUM_PLAT,
    parameter int SIZE        = DEF_SIZE,
    parameter int PLAT_W      = DEF_PLAT_W,
    parameter int GRAVITY     = DEF_GRAVITY,
    parameter int JUMP_V      = DEF_JUMP_V,
    parameter int V_MAX       = DEF_V_MAX,
    parameter int Y_START     = DEF_Y_START,
    parameter int Y_TOP       = DEF_Y_TOP,
    parameter int Y_FLOOR     = DEF_Y_FLOOR,
    parameter int SCROLL_LINE = DEF_SCROLL_LINE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          terminated,
    input  logic [NUM_PLAT*Y_W-1:0]       plat_vpos,
    input  logic [NUM_PLAT*Y_W-1:0]       plat_hpos,
    input  logic [Y_W-1:0]                d_x,
    output logic [Y_W-1:0]                d_y,
    output logic signed [V_W-1:0]         v_y,
    output logic                          landed,
    output logic [$clog2(NUM_PLAT)-1:0]   land_idx,
    output logic                          fell,
    output logic [Y_W-1:0]                scroll_dy
);
    localparam int S  = Y_W + 2;
    localparam int IW = $clog2(NUM_PLAT);
`ifdef DOODLE_SCROLL_EN
    localparam bit SCROLL_EN = 1'b1;
`else
    localparam bit SCROLL_EN = 1'b0;
`endif
    localparam int CLAMP = SCROLL_EN ? SCROLL_LINE : Y_TOP;
    state_e state_q, state_d;
    logic [Y_W-1:0] dy_q, dy_d, sdy_q, sdy_d;
    logic signed [V_W-1:0] vy_q, vy_d;
    logic landed_q, landed_d, fell_q, fell_d;
    logic [IW-1:0] idx_q, idx_d, hit_idx;
    logic [NUM_PLAT-1:0] hit;
    logic signed [S-1:0] dy_s, vy_s, ny, nv, vf, yf;
    assign dy_s = $signed({2'b00, dy_q});
    assign vy_s = S'(vy_q);
    assign ny   = dy_s + vy_s;
    assign nv   = vy_s + S'(GRAVITY);
    assign vf   = (nv > S'(V_MAX)) ? S'(V_MAX) : nv;
    assign yf   = dy_s + vf;
    for (genvar g = 0; g < NUM_PLAT; g++) begin : g_hit
        plat_hit_detect #(.Y_W(Y_W), .SIZE(SIZE), .PLAT_W(PLAT_W)) u_hit (
            .d_y  (dy_s),
            .y_nxt(yf),
            .d_x  (d_x),
            .vpos (plat_vpos[plat_lsb(g, Y_W) +: Y_W]),
            .hpos (plat_hpos[plat_lsb(g, Y_W) +: Y_W]),
            .hit  (hit[g])
        );
    end
    // Scanning downward leaves the lowest hitting index as the winner.
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--)
            if (hit[i]) hit_idx = IW'(i);
    end
    always_comb begin
        state_d  = state_q;
        dy_d     = dy_q;
        vy_d     = vy_q;
        landed_d = 1'b0;
        idx_d    = idx_q;
        fell_d   = fell_q;
        sdy_d    = '0;
        if (terminated) begin
            state_d = IDLE;
        end else if (tick) begin
            case (state_q)
                IDLE: if (start) begin
                    vy_d    = V_W'(-JUMP_V);
                    state_d = RISE;
                end
                RISE: begin
                    dy_d    = (ny < S'(CLAMP)) ? Y_W'(CLAMP) : Y_W'(ny);
                    sdy_d   = (SCROLL_EN && ny < S'(CLAMP)) ? Y_W'(S'(CLAMP) - ny) : '0;
                    vy_d    = V_W'(nv);
                    state_d = nv[S-1] ? RISE : FALL;
                end
                FALL: if (|hit) begin
                    dy_d     = plat_vpos[plat_lsb(int'(hit_idx), Y_W) +: Y_W] - Y_W'(SIZE);
                    vy_d     = V_W'(-JUMP_V);
                    landed_d = 1'b1;
                    idx_d    = hit_idx;
                    state_d  = RISE;
                end else if (yf + S'(SIZE) > S'(Y_FLOOR)) begin
                    dy_d    = Y_W'(Y_FLOOR - SIZE);
                    vy_d    = '0;
                    fell_d  = 1'b1;
                    state_d = DEAD;
                end else begin
                    dy_d = Y_W'(yf);
                    vy_d = V_W'(vf);
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dy_q     <= Y_W'(Y_START);
            vy_q     <= '0;
            landed_q <= 1'b0;
            idx_q    <= '0;
            fell_q   <= 1'b0;
            sdy_q    <= '0;
        end else begin
            state_q  <= state_d;
            dy_q     <= dy_d;
            vy_q     <= vy_d;
            landed_q <= landed_d;
            idx_q    <= idx_d;
            fell_q   <= fell_d;
            sdy_q    <= sdy_d;
        end
    end
    assign d_y       = dy_q;
    assign v_y       = vy_q;
    assign landed    = landed_q;
    assign land_idx  = idx_q;
    assign fell      = fell_q;
    assign scroll_dy = sdy_q;
endmodule
